// File: rtl/chunked_addsub_if.sv
// Handshake and operand/result bundle for chunked_addsub.
// The sat signal exists only when CHUNKED_ADDSUB_SAT_EN is defined.
interface chunked_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic             ci;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ov;
`ifdef CHUNKED_ADDSUB_SAT_EN
    logic             sat;
`endif

    modport master (
        output in_valid, mode, ci, a, b, out_ready,
`ifdef CHUNKED_ADDSUB_SAT_EN
        output sat,
`endif
        input  in_ready, out_valid, res, co, ov
    );

    modport slave (
        input  in_valid, mode, ci, a, b, out_ready,
`ifdef CHUNKED_ADDSUB_SAT_EN
        input  sat,
`endif
        output in_ready, out_valid, res, co, ov
    );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock with a registered carry chain.
// Optional unsigned saturation is enabled by defining CHUNKED_ADDSUB_SAT_EN.
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    chunked_addsub_if.slave  bus
);
    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("chunked_addsub: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bp_q, bp_d;      // b already inverted for subtract
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
`ifdef CHUNKED_ADDSUB_SAT_EN
    logic             sat_q, sat_d;
`endif

    logic [31:0]      lsb;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] res_raw;
    logic             co_raw;

    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bp_d    = bp_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        co_d    = co_q;
        ov_d    = ov_q;
`ifdef CHUNKED_ADDSUB_SAT_EN
        sat_d   = sat_q;
`endif
        lsb     = 32'(idx_q) * 32'(CHUNK);
        a_sl    = CHUNK'(a_q >> lsb);
        b_sl    = CHUNK'(bp_q >> lsb);
        sum     = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        res_raw = (res_q & ~(SLICE_MASK << lsb)) | (WIDTH'(sum[CHUNK-1:0]) << lsb);
        co_raw  = sum[CHUNK] ^ mode_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    bp_d    = bus.b ^ {WIDTH{bus.mode}};
                    mode_d  = bus.mode;
                    carry_d = bus.ci ^ bus.mode;
                    idx_d   = '0;
`ifdef CHUNKED_ADDSUB_SAT_EN
                    sat_d   = bus.sat;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d   = res_raw;
                carry_d = sum[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    idx_d   = '0;
                    co_d    = co_raw;
                    // overflow is judged on the unsaturated sum
                    ov_d    = (a_q[WIDTH-1] == bp_q[WIDTH-1]) && (res_raw[WIDTH-1] != a_q[WIDTH-1]);
`ifdef CHUNKED_ADDSUB_SAT_EN
                    if (sat_q && co_raw) res_d = mode_q ? '0 : '1;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            bp_q    <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef CHUNKED_ADDSUB_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bp_q    <= bp_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
`ifdef CHUNKED_ADDSUB_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.res       = res_q;
    assign bus.co        = co_q;
    assign bus.ov        = ov_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// Directed and random checks of chunked_addsub (WIDTH=32, CHUNK=8) against an arithmetic model.
module tb_chunked_addsub;
    localparam int W  = 32;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    chunked_addsub_if #(.WIDTH(W)) ifc ();
    chunked_addsub #(.WIDTH(W), .CHUNK(8)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ov, co, res} from plain integer arithmetic
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic m, input logic c, input logic s);
        longint      sa, sb, sr;
        logic [32:0] full;
        logic [31:0] r;
        logic        co, ov;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (!m) begin
            full = {1'b0, a} + {1'b0, b} + 33'(c);
            r    = full[31:0];
            co   = full[32];
            sr   = sa + sb + longint'(c);
        end else begin
            r    = a - b - 32'(c);
            co   = ({1'b0, a} < ({1'b0, b} + 33'(c)));
            sr   = sa - sb - longint'(c);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (s && co) r = m ? 32'h0 : 32'hFFFF_FFFF;
        return {ov, co, r};
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic m, input logic c, input logic s, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
        ifc.a = a; ifc.b = b; ifc.mode = m; ifc.ci = c;
`ifdef CHUNKED_ADDSUB_SAT_EN
        ifc.sat = s;
`endif
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [33:0] exp, input string tag);
        int lat;
        lat = 1;
        while (!ifc.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NC + 1));
        check({tag, "_res"}, ifc.res, exp[31:0]);
        check({tag, "_co"},  32'(ifc.co), 32'(exp[32]));
        check({tag, "_ov"},  32'(ifc.ov), 32'(exp[33]));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(ifc.in_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(ifc.out_valid), 32'd0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic c, input logic s, input string tag);
        start_op(a, b, m, c, s, tag);
        wait_done(model(a, b, m, c, s), tag);
        release_out(tag);
    endtask

    initial begin
        logic [33:0] held;
        logic [31:0] ra, rb;
        logic        rm, rc, rs;

        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        ifc.mode = 1'b0; ifc.ci = 1'b0; ifc.a = '0; ifc.b = '0;
`ifdef CHUNKED_ADDSUB_SAT_EN
        ifc.sat = 1'b0;
`endif
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(ifc.in_ready), 32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_res",       ifc.res, 32'd0);
        check("rst_co",        32'(ifc.co), 32'd0);
        check("rst_ov",        32'(ifc.ov), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed corner cases
        do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, "add_wrap");
        do_op(32'h0100_0000, 32'h1, 1'b1, 1'b0, 1'b0, "sub_borrow_chain");
        do_op(32'h5, 32'h7, 1'b1, 1'b0, 1'b0, "sub_neg");
        do_op(32'h10, 32'h0F, 1'b1, 1'b1, 1'b0, "sub_bin");
        do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, "add_ov");
        do_op(32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b0, "sub_ov");
        do_op(32'h0000_00FF, 32'h0, 1'b0, 1'b1, 1'b0, "add_cin");

        // backpressure: result must hold and new operands be ignored
        start_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, "bp");
        held = model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
        wait_done(held, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ifc.in_valid = (i == 3);
            ifc.a = 32'hDEAD_BEEF; ifc.b = 32'h1111_1111; ifc.mode = 1'b1;
            @(posedge clk);
            #1;
            check("bp_hold_res",   ifc.res, held[31:0]);
            check("bp_hold_co",    32'(ifc.co), 32'(held[32]));
            check("bp_hold_ov",    32'(ifc.ov), 32'(held[33]));
            check("bp_in_ready",   32'(ifc.in_ready), 32'd0);
            check("bp_out_valid",  32'(ifc.out_valid), 32'd1);
        end
        ifc.in_valid = 1'b0;
        release_out("bp");
        do_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0, 1'b0, "bp_next");

        // reset in the second CALC cycle
        start_op(32'hA5A5_A5A5, 32'h1234_4321, 1'b0, 1'b1, 1'b0, "rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_mid_res",       ifc.res, 32'd0);
        check("rst_mid_co",        32'(ifc.co), 32'd0);
        check("rst_mid_ov",        32'(ifc.ov), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready",  32'(ifc.in_ready), 32'd1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef CHUNKED_ADDSUB_SAT_EN
        do_op(32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 1'b1, "sat_add");
        do_op(32'h3, 32'h4, 1'b1, 1'b0, 1'b1, "sat_sub");
        do_op(32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 1'b0, "nosat_add");
        do_op(32'h3, 32'h4, 1'b1, 1'b0, 1'b0, "nosat_sub");
`endif

        // random operations
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) ra = 32'h7FFF_FFFF;
            if (i % 8 == 1) rb = 32'h8000_0000;
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rs = 1'b0;
`ifdef CHUNKED_ADDSUB_SAT_EN
            rs = 1'($urandom_range(0, 1));
`endif
            do_op(ra, rb, rm, rc, rs, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
